// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE_ST  = 1'b0,
        SHIFT_ST = 1'b1
    } state_t;

    localparam int unsigned SYNC_STAGES   = 3;
    localparam logic [7:0]  IDLE_WORD_DEF = 8'hFF;

endpackage

// File: rtl/bit_sync.sv
// Multi-stage synchronizer for one asynchronous input bit.
// Exposes the last two stages so the parent can detect edges between them.
module bit_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic stage2,
    output logic stage3
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign stage2 = sr[SYNC_STAGES-2];
    assign stage3 = sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slv_ctrl.sv
// SPI mode-0 responder: synchronizes SCLK/MOSI/CS_N, shifts receive words in,
// shifts transmit words out of a single-entry holding register.
module spi_slv_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned   DW        = 8,
    parameter logic [DW-1:0] IDLE_WORD = DW'(IDLE_WORD_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          mosi,
    input  logic          cs_n,
    output logic          miso,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid_f,
    output logic          tx_ready_f,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid_f,
    output logic          udr_f,
    output logic          busy_f
);

    localparam int unsigned CW = $clog2(DW);

    logic sclk_s2, sclk_s3;
    logic mosi_s, mosi_d;
    logic cs_s2, cs_s3;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic unused_mosi;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt_bits, cnt_nxt;
    logic          word_done, done_nxt;
    logic [DW-1:0] rx_sr, rx_sr_nxt;
    logic [DW-1:0] tx_sr, tx_sr_nxt;
    logic [DW-1:0] hold_data, hold_nxt;
    logic          ready_nxt;
    logic [DW-1:0] rx_data_nxt;
    logic          rx_valid_nxt, udr_nxt, oe_nxt, miso_nxt, busy_nxt;
    logic          load;

    bit_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .stage2(sclk_s2), .stage3(sclk_s3)
    );

    bit_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .stage2(mosi_s), .stage3(mosi_d)
    );

    // CS_N resets low so a select still held across reset release is not seen as a fresh fall.
    bit_sync #(.RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .stage2(cs_s2), .stage3(cs_s3)
    );

    assign unused_mosi = mosi_d;
    assign sclk_rise   = sclk_s2 & ~sclk_s3;
    assign sclk_fall   = ~sclk_s2 & sclk_s3;
    assign cs_fall     = ~cs_s2 & cs_s3;
    assign cs_rise     = cs_s2 & ~cs_s3;

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt_bits;
        done_nxt     = word_done;
        rx_sr_nxt    = rx_sr;
        tx_sr_nxt    = tx_sr;
        hold_nxt     = hold_data;
        ready_nxt    = tx_ready_f;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        udr_nxt      = 1'b0;
        oe_nxt       = miso_oe;
        load         = 1'b0;

        case (state)
            IDLE_ST: begin
                if (cs_fall) begin
                    state_nxt = SHIFT_ST;
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                    oe_nxt    = 1'b1;
                end
            end
            SHIFT_ST: begin
                // Deselect wins over a coincident clock edge; partial word is dropped.
                if (cs_rise) begin
                    state_nxt = IDLE_ST;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                    oe_nxt    = 1'b0;
                end else if (sclk_rise) begin
                    rx_sr_nxt = {rx_sr[DW-2:0], mosi_s};
                    if (cnt_bits == CW'(DW-1)) begin
                        rx_data_nxt  = rx_sr_nxt;
                        rx_valid_nxt = 1'b1;
                        cnt_nxt      = '0;
                        done_nxt     = 1'b1;
                    end else begin
                        cnt_nxt = cnt_bits + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (word_done) begin
                        load     = 1'b1;
                        done_nxt = 1'b0;
                    end else begin
                        tx_sr_nxt = {tx_sr[DW-2:0], 1'b0};
                    end
                end
            end
            default: state_nxt = IDLE_ST;
        endcase

        // Word load sees the holding register as it was before this cycle's write.
        if (load) begin
            if (!tx_ready_f) begin
                tx_sr_nxt = hold_data;
                ready_nxt = 1'b1;
            end else begin
                tx_sr_nxt = IDLE_WORD;
                udr_nxt   = 1'b1;
            end
        end

        if (tx_valid_f && tx_ready_f) begin
            hold_nxt  = tx_data;
            ready_nxt = 1'b0;
        end

        miso_nxt = oe_nxt ? tx_sr_nxt[DW-1] : 1'b0;
        busy_nxt = (state_nxt == SHIFT_ST);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE_ST;
            cnt_bits   <= '0;
            word_done  <= 1'b0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            hold_data  <= '0;
            tx_ready_f <= 1'b1;
            rx_data    <= '0;
            rx_valid_f <= 1'b0;
            udr_f      <= 1'b0;
            miso_oe    <= 1'b0;
            miso       <= 1'b0;
            busy_f     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt_bits   <= cnt_nxt;
            word_done  <= done_nxt;
            rx_sr      <= rx_sr_nxt;
            tx_sr      <= tx_sr_nxt;
            hold_data  <= hold_nxt;
            tx_ready_f <= ready_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid_f <= rx_valid_nxt;
            udr_f      <= udr_nxt;
            miso_oe    <= oe_nxt;
            miso       <= miso_nxt;
            busy_f     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_slv_ctrl.sv
// Bench for spi_slv_ctrl: bit-banged mode-0 master plus a word-level model
// of the transmit holding register.
module tb_spi_slv_ctrl;

    localparam int unsigned H = 8;   // SCLK half period in CLK cycles

    logic       clk = 1'b0;
    logic       rst, sclk, mosi, cs_n;
    logic       miso, miso_oe, tx_valid_f, tx_ready_f, rx_valid_f, udr_f, busy_f;
    logic [7:0] tx_data, rx_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int         udr_cnt = 0;

    // Model of the holding register and of expected underruns.
    logic       m_full  = 1'b0;
    logic [7:0] m_hold  = 8'h00;
    int         exp_udr = 0;

    logic [7:0] mo_w[4];
    logic [7:0] mi_w[4];
    logic [7:0] exp_mi[4];
    logic [7:0] rf_d[4];
    logic       rf_en[4];

    spi_slv_ctrl dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid_f(tx_valid_f), .tx_ready_f(tx_ready_f),
        .rx_data(rx_data), .rx_valid_f(rx_valid_f), .udr_f(udr_f), .busy_f(busy_f)
    );

    always #5 clk = ~clk;

    // Record received words and underrun strobes.
    always @(negedge clk) begin
        if (!rst && rx_valid_f) rx_q.push_back(rx_data);
        if (!rst && udr_f) udr_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] model_load();
        if (m_full) begin
            m_full = 1'b0;
            return m_hold;
        end
        exp_udr++;
        return 8'hFF;
    endfunction

    task automatic tx_write(input logic [7:0] d);
        n_checks++;
        if (tx_ready_f !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_before_write: got %b want 1", tx_ready_f);
        end
        tx_data    = d;
        tx_valid_f = 1'b1;
        @(negedge clk);
        tx_valid_f = 1'b0;
        m_full     = 1'b1;
        m_hold     = d;
    endtask

    // Full transfer of n words in one CS window; CS is released while SCLK is
    // still high so the trailing fall does not trigger another word load.
    task automatic run_xfer(input int n);
        cs_n      = 1'b0;
        exp_mi[0] = model_load();
        for (int k = 0; k < n; k++) begin
            for (int b = 7; b >= 0; b--) begin
                mosi = mo_w[k][b];
                if (b == 4 && rf_en[k] && !m_full) begin
                    tx_write(rf_d[k]);
                    repeat (H-1) @(negedge clk);
                end else begin
                    repeat (H) @(negedge clk);
                end
                sclk       = 1'b1;
                mi_w[k][b] = miso;
                n_checks++;
                if (miso_oe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL miso_oe_in_xfer: got %b want 1", miso_oe);
                end
                repeat (H) @(negedge clk);
                if (k == n-1 && b == 0) begin
                    cs_n = 1'b1;
                    repeat (2) @(negedge clk);
                    sclk = 1'b0;
                end else begin
                    sclk = 1'b0;
                    if (b == 0) exp_mi[k+1] = model_load();
                end
            end
        end
        repeat (2*H) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_valid_f = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({miso, miso_oe, tx_ready_f, rx_valid_f, udr_f, busy_f} !== 6'b001000 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_in: flags %b rx %h want 001000 00",
                     {miso, miso_oe, tx_ready_f, rx_valid_f, udr_f, busy_f}, rx_data);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({miso, miso_oe, tx_ready_f, rx_valid_f, udr_f, busy_f} !== 6'b001000 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out: flags %b rx %h want 001000 00",
                     {miso, miso_oe, tx_ready_f, rx_valid_f, udr_f, busy_f}, rx_data);
        end
        m_full = 1'b0;
        tx_write(8'hA5);
        n_checks++;
        if (tx_ready_f !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_write: got %b want 0", tx_ready_f);
        end
    endtask

    task automatic test_single();
        int u0;
        u0 = udr_cnt;
        rx_q.delete();
        mo_w[0] = 8'h3C; rf_en[0] = 1'b0;
        run_xfer(1);
        n_checks++;
        if (mi_w[0] !== 8'hA5) begin
            n_fail++; $display("FAIL single_miso: got %h want a5", mi_w[0]);
        end
        n_checks++;
        if (rx_q.size() != 1 || rx_data !== 8'h3C) begin
            n_fail++; $display("FAIL single_rx: pulses %0d data %h want 1 3c", rx_q.size(), rx_data);
        end
        n_checks++;
        if (udr_cnt - u0 != 0 || tx_ready_f !== 1'b1 || busy_f !== 1'b0) begin
            n_fail++;
            $display("FAIL single_flags: udr %0d ready %b busy %b want 0 1 0", udr_cnt - u0, tx_ready_f, busy_f);
        end
    endtask

    task automatic test_back_to_back();
        int u0;
        u0 = udr_cnt;
        rx_q.delete();
        tx_write(8'h12);
        mo_w[0] = 8'h81; rf_en[0] = 1'b1; rf_d[0] = 8'h34;
        mo_w[1] = 8'h7E; rf_en[1] = 1'b0;
        run_xfer(2);
        n_checks++;
        if (mi_w[0] !== 8'h12 || mi_w[1] !== 8'h34) begin
            n_fail++; $display("FAIL b2b_miso: got %h %h want 12 34", mi_w[0], mi_w[1]);
        end
        n_checks++;
        if (rx_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size());
        end else if (rx_q[0] !== 8'h81 || rx_q[1] !== 8'h7E) begin
            n_fail++; $display("FAIL b2b_rx_data: got %h %h want 81 7e", rx_q[0], rx_q[1]);
        end
        n_checks++;
        if (udr_cnt - u0 != 0) begin
            n_fail++; $display("FAIL b2b_udr: got %0d want 0", udr_cnt - u0);
        end
    endtask

    task automatic test_underrun();
        int u0;
        u0 = udr_cnt;
        rx_q.delete();
        mo_w[0] = 8'h00; rf_en[0] = 1'b0;
        run_xfer(1);
        n_checks++;
        if (mi_w[0] !== 8'hFF) begin
            n_fail++; $display("FAIL udr_miso: got %h want ff", mi_w[0]);
        end
        n_checks++;
        if (udr_cnt - u0 != 1) begin
            n_fail++; $display("FAIL udr_count: got %0d want 1", udr_cnt - u0);
        end
        n_checks++;
        if (rx_q.size() != 1 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL udr_rx: pulses %0d data %h want 1 00", rx_q.size(), rx_data);
        end
    endtask

    task automatic test_abort();
        logic [7:0] w;
        w = 8'hC3;
        rx_q.delete();
        cs_n = 1'b0;
        void'(model_load());
        for (int b = 7; b >= 3; b--) begin
            mosi = w[b];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (2*H) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0 || busy_f !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: pulses %0d busy %b oe %b miso %b want 0 0 0 0",
                     rx_q.size(), busy_f, miso_oe, miso);
        end
        mo_w[0] = w; rf_en[0] = 1'b0;
        run_xfer(1);
        n_checks++;
        if (rx_q.size() != 1 || rx_data !== 8'hC3 || mi_w[0] !== exp_mi[0]) begin
            n_fail++;
            $display("FAIL abort_next: pulses %0d rx %h miso %h want 1 c3 %h",
                     rx_q.size(), rx_data, mi_w[0], exp_mi[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'hE7;
        rx_q.delete();
        cs_n = 1'b0;
        void'(model_load());
        for (int b = 7; b >= 5; b--) begin
            mosi = w[b];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({miso, miso_oe, tx_ready_f, rx_valid_f, udr_f, busy_f} !== 6'b001000 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_values: flags %b rx %h want 001000 00",
                     {miso, miso_oe, tx_ready_f, rx_valid_f, udr_f, busy_f}, rx_data);
        end
        rst    = 1'b0;
        m_full = 1'b0;
        // CS_N still low: clocking must be ignored until a fresh select.
        for (int b = 7; b >= 0; b--) begin
            mosi = w[b];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy_f !== 1'b0 || miso_oe !== 1'b0 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_ignore: busy %b oe %b pulses %0d want 0 0 0", busy_f, miso_oe, rx_q.size());
        end
        cs_n = 1'b1;
        repeat (2*H) @(negedge clk);
        mo_w[0] = 8'h5A; rf_en[0] = 1'b0;
        run_xfer(1);
        n_checks++;
        if (rx_q.size() != 1 || rx_data !== 8'h5A || mi_w[0] !== 8'hFF) begin
            n_fail++;
            $display("FAIL midrst_next: pulses %0d rx %h miso %h want 1 5a ff", rx_q.size(), rx_data, mi_w[0]);
        end
    endtask

    task automatic test_random();
        int n, u0, e0;
        for (int t = 0; t < 6; t++) begin
            rx_q.delete();
            u0 = udr_cnt;
            e0 = exp_udr;
            n  = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1 && !m_full) tx_write(8'($urandom));
            for (int k = 0; k < n; k++) begin
                mo_w[k]  = 8'($urandom);
                rf_en[k] = 1'($urandom_range(0, 1));
                rf_d[k]  = 8'($urandom);
            end
            run_xfer(n);
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (mi_w[k] !== exp_mi[k]) begin
                    n_fail++; $display("FAIL rand_miso[%0d.%0d]: got %h want %h", t, k, mi_w[k], exp_mi[k]);
                end
                n_checks++;
                if (rx_q.size() <= k) begin
                    n_fail++; $display("FAIL rand_rx_missing[%0d.%0d]: got %0d words", t, k, rx_q.size());
                end else if (rx_q[k] !== mo_w[k]) begin
                    n_fail++; $display("FAIL rand_rx[%0d.%0d]: got %h want %h", t, k, rx_q[k], mo_w[k]);
                end
            end
            n_checks++;
            if (rx_q.size() != n || udr_cnt - u0 != exp_udr - e0) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: rx %0d udr %0d want %0d %0d",
                         t, rx_q.size(), udr_cnt - u0, n, exp_udr - e0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
